// File: rtl/unified_memory_arbiter_if.sv
// unified_memory_arbiter_if: fetch, load/store and memory-macro signals of the shared-memory arbiter
interface unified_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_ack_o;
  logic [31:0]           if_rdata_o;
  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [31:0]           d_wdata_i;
  logic                  d_ack_o;
  logic [31:0]           d_rdata_o;
  logic                  d_err_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;
  logic                  busy_o;
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, d_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o, d_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one fixed-latency single-port memory between fetch and load/store ports
module unified_memory_arbiter #(
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input logic clk,
  input logic reset,
  unified_memory_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  own_d_q, own_d_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  pick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      own_d_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      own_d_q    <= own_d_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    pick_d     = bus.d_req_i & (~bus.if_req_i | (streak_q != STREAK_MAX));
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    own_d_d    = own_d_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: if (bus.if_req_i | bus.d_req_i) begin
        own_d_d  = pick_d;
        we_d     = pick_d & bus.d_we_i;
        err_d    = pick_d & (bus.d_addr_i[1:0] != 2'b00);
        addr_d   = pick_d ? bus.d_addr_i : bus.if_addr_i;
        wdata_d  = bus.d_wdata_i;
        streak_d = (pick_d & bus.if_req_i) ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1)) : '0;
        state_d  = err_d ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d   = 4'(MEM_LATENCY - 1);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          if_rdata_d = own_d_q ? if_rdata_q : bus.mem_rdata_i;
          d_rdata_d  = own_d_q ? bus.mem_rdata_i : d_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en_o    = state_q == ISSUE;
    bus.mem_we_o    = (state_q == ISSUE) & we_q;
    bus.if_ack_o    = (state_q == RESP) & ~own_d_q;
    bus.d_ack_o     = (state_q == RESP) & own_d_q;
    bus.d_err_o     = (state_q == RESP) & own_d_q & err_q;
    bus.busy_o      = state_q != IDLE;
    bus.mem_addr_o  = addr_q;
    bus.mem_wdata_o = wdata_q;
    bus.if_rdata_o  = if_rdata_q;
    bus.d_rdata_o   = d_rdata_q;
  end
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb_unified_memory_arbiter: randomized bench checked every cycle against a transaction-level model
module tb_unified_memory_arbiter;
  localparam int L  = 2;
  localparam int MS = 4;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  unified_memory_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  unified_memory_arbiter #(.MEM_LATENCY(L), .MAX_DATA_STREAK(MS), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] tb_mem [logic [31:0]];
  bit act = 0, od, mwe, merr, post_rst;
  int tg = 0, ta = 0, streak = 0, due = -1;
  logic [31:0] maddr, mwdata, mrdata, exp_if, exp_d, exp_addr, due_data;
  int last_en = -1, last_ifa = -1, last_da = -1, acks = 0;
  bit last_we, last_err;
  logic [5:0] seq = '0;
  int c0, a0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h0000_0100 + ($urandom_range(0, 15) << 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic model_grant();
    if (reset) begin
      act = 0; streak = 0; exp_if = '0; exp_d = '0; exp_addr = '0; post_rst = 1;
      return;
    end
    if ((!act || cyc > ta) && (bus.if_req_i || bus.d_req_i)) begin
      od = bus.d_req_i && (!bus.if_req_i || streak < MS);
      streak = (od && bus.if_req_i) ? ((streak < MS) ? streak + 1 : MS) : 0;
      mwe = od && bus.d_we_i;
      merr = od && (bus.d_addr_i[1:0] != 2'b00);
      maddr = od ? bus.d_addr_i : bus.if_addr_i;
      mwdata = bus.d_wdata_i;
      tg = cyc;
      ta = cyc + (merr ? 1 : mwe ? 2 : L + 2);
      act = 1;
      if (mwe && !merr) ref_mem[maddr] = mwdata;
      mrdata = ref_mem.exists(maddr) ? ref_mem[maddr] : init_word(maddr);
    end
  endtask

  task automatic check();
    bit busy_e, en_e, ifa_e, da_e;
    busy_e = act && cyc > tg && cyc <= ta;
    en_e = act && !merr && cyc == tg + 1;
    ifa_e = act && cyc == ta && !od;
    da_e = act && cyc == ta && od;
    if (act && cyc == tg + 1) exp_addr = maddr;
    if (act && cyc == ta && !mwe && !merr) begin
      if (od) exp_d = mrdata;
      else exp_if = mrdata;
    end
    chk("busy", 32'(bus.busy_o), 32'(busy_e));
    chk("mem_en", 32'(bus.mem_en_o), 32'(en_e));
    chk("mem_we", 32'(bus.mem_we_o), 32'(en_e && mwe));
    if (en_e && mwe) chk("mem_wdata", bus.mem_wdata_o, mwdata);
    if (post_rst) begin
      chk("wdata_after_reset", bus.mem_wdata_o, 32'h0);
      post_rst = 0;
    end
    chk("mem_addr", bus.mem_addr_o, exp_addr);
    chk("if_ack", 32'(bus.if_ack_o), 32'(ifa_e));
    chk("d_ack", 32'(bus.d_ack_o), 32'(da_e));
    chk("d_err", 32'(bus.d_err_o), 32'(da_e && merr));
    chk("if_rdata", bus.if_rdata_o, exp_if);
    chk("d_rdata", bus.d_rdata_o, exp_d);
    if (bus.mem_en_o) begin last_en = cyc; last_we = bus.mem_we_o; end
    if (bus.if_ack_o) begin last_ifa = cyc; seq = {seq[4:0], 1'b0}; acks++; end
    if (bus.d_ack_o) begin last_da = cyc; last_err = bus.d_err_o; seq = {seq[4:0], 1'b1}; acks++; end
  endtask

  task automatic mem_step();
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) tb_mem[bus.mem_addr_o] = bus.mem_wdata_o;
      else begin
        due = cyc + L;
        due_data = tb_mem.exists(bus.mem_addr_o) ? tb_mem[bus.mem_addr_o] : init_word(bus.mem_addr_o);
      end
    end
    bus.mem_rdata_i = (cyc == due) ? due_data : $urandom;
  endtask

  task automatic tick();
    model_grant();
    @(negedge clk);
    cyc++;
    check();
    mem_step();
    if (bus.if_ack_o) bus.if_req_i = 1'b0;
    if (bus.d_ack_o) bus.d_req_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bus.if_req_i || bus.d_req_i) && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(bus.if_req_i || bus.d_req_i), 32'h0);
    tick();
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.d_req_i = 0; bus.d_we_i = 0;
    bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.mem_rdata_i = '0;
    ref_mem[32'h0040_0000] = 32'h0050_0093;
    tb_mem[32'h0040_0000] = 32'h0050_0093;
    tick();
    reset = 0;
    tick();
    c0 = cyc; bus.if_addr_i = 32'h0040_0000; bus.if_req_i = 1;
    drain("t1");
    chk("t1_en_cycle", 32'(last_en - c0), 32'd1);
    chk("t1_ack_cycle", 32'(last_ifa - c0), 32'd4);
    chk("t1_rdata", bus.if_rdata_o, 32'h0050_0093);
    c0 = cyc; bus.d_addr_i = 32'h10; bus.d_wdata_i = 32'hDEAD_BEEF; bus.d_we_i = 1; bus.d_req_i = 1;
    drain("t2");
    chk("t2_en_cycle", 32'(last_en - c0), 32'd1);
    chk("t2_we", 32'(last_we), 32'd1);
    chk("t2_ack_cycle", 32'(last_da - c0), 32'd2);
    chk("t2_if_rdata_kept", bus.if_rdata_o, 32'h0050_0093);
    c0 = cyc; bus.d_addr_i = 32'h14; bus.d_wdata_i = $urandom; bus.d_we_i = 1; bus.d_req_i = 1; bus.if_req_i = 1;
    drain("t3");
    chk("t3_d_ack_cycle", 32'(last_da - c0), 32'd2);
    chk("t3_if_ack_cycle", 32'(last_ifa - c0), 32'd7);
    a0 = acks;
    for (int n = 0; n < 100 && acks - a0 < 6; n++) begin
      if (!bus.if_req_i) begin bus.if_req_i = 1; bus.if_addr_i = rand_addr(); end
      if (!bus.d_req_i) begin bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = rand_addr(); end
      tick();
    end
    chk("t4_grant_order", 32'(seq), 32'h3D);
    drain("t4");
    c0 = cyc; bus.d_addr_i = 32'h13; bus.d_we_i = 0; bus.d_req_i = 1;
    drain("t5");
    chk("t5_ack_cycle", 32'(last_da - c0), 32'd1);
    chk("t5_err", 32'(last_err), 32'd1);
    chk("t5_no_mem_en", 32'(last_en >= c0), 32'd0);
    c0 = cyc; a0 = acks; bus.if_addr_i = 32'h0040_0000; bus.if_req_i = 1;
    tick();
    tick();
    reset = 1; bus.if_req_i = 0;
    tick();
    reset = 0;
    chk("t6_busy_after_reset", 32'(bus.busy_o), 32'd0);
    chk("t6_rdata_after_reset", bus.if_rdata_o, 32'h0);
    tick();
    chk("t6_no_ack", 32'(acks - a0), 32'd0);
    c0 = cyc; bus.if_req_i = 1;
    drain("t6");
    chk("t6_ack_cycle", 32'(last_ifa - c0), 32'd4);
    chk("t6_rdata", bus.if_rdata_o, 32'h0050_0093);
    for (int n = 0; n < 3000; n++) begin
      reset = 0;
      if (!bus.if_req_i && $urandom_range(0, 3) == 0) begin
        bus.if_req_i = 1; bus.if_addr_i = rand_addr();
      end
      if (!bus.d_req_i && $urandom_range(0, 2) == 0) begin
        bus.d_req_i = 1;
        bus.d_we_i = 1'($urandom_range(0, 1));
        bus.d_addr_i = rand_addr() | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        bus.d_wdata_i = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; bus.if_req_i = 0; bus.d_req_i = 0;
      end
      tick();
    end
    reset = 0;
    drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
